alu_result_serializer: RTL and testbench

Downstream stage of the ALU. Captures each registered 16-bit ALU result (one-cycle valid pulse) and emits it as two bytes, low byte first, over a valid/ready byte interface toward the TX FIFO / UART transmit path. A one-entry pending buffer absorbs one result arriving while a previous one is still draining. Further results are dropped and counted.

---
 rtl/alu_result_serializer_pkg.sv | 12 +
 rtl/alu_result_serializer.sv | 110 +++++++++++
 tb/tb_alu_result_serializer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alu_result_serializer_pkg.sv
// Shared constants for the ALU result serializer: FSM encodings and the
// default result/byte widths so the ALU and this block agree.
package alu_result_serializer_pkg;

  localparam int DEF_BYTE_WIDTH = 8;
  localparam int DEF_OUT_WIDTH  = 2 * DEF_BYTE_WIDTH;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_SEND_LO = 2'b01;
  localparam logic [1:0] ST_SEND_HI = 2'b10;

endpackage

// File: rtl/alu_result_serializer.sv
// Splits each 16-bit ALU result into two bytes (low first) on a valid/ready
// byte interface, with a one-entry pending buffer and a saturating drop counter.
module alu_result_serializer
  import alu_result_serializer_pkg::*;
#(
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [OUT_WIDTH-1:0]  ALU_OUT,
  input  logic                  OUT_VALID,
  output logic [BYTE_WIDTH-1:0] TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  BUSY,
  output logic                  OVERFLOW,
  output logic [CNT_WIDTH-1:0]  DROP_CNT
);

  logic [1:0]           state, nxt_state;
  logic [OUT_WIDTH-1:0] active, nxt_active;
  logic [OUT_WIDTH-1:0] pend, nxt_pend;
  logic                 pend_vld, nxt_pend_vld;
  logic                 drop;
  logic                 hs;
  logic                 park;

  assign hs = (state != ST_IDLE) && TX_READY;

  // A result that cannot go straight into active is parked in pending,
  // or dropped when pending is already occupied and not being drained.
  always_comb begin
    nxt_state    = state;
    nxt_active   = active;
    nxt_pend     = pend;
    nxt_pend_vld = pend_vld;
    drop         = 1'b0;
    park         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (OUT_VALID) begin
          nxt_active = ALU_OUT;
          nxt_state  = ST_SEND_LO;
        end
      end
      ST_SEND_LO: begin
        if (hs) nxt_state = ST_SEND_HI;
        park = OUT_VALID;
      end
      ST_SEND_HI: begin
        if (hs && pend_vld) begin
          nxt_active   = pend;
          nxt_state    = ST_SEND_LO;
          nxt_pend_vld = OUT_VALID;
          if (OUT_VALID) nxt_pend = ALU_OUT;
        end else if (hs && OUT_VALID) begin
          nxt_active = ALU_OUT;
          nxt_state  = ST_SEND_LO;
        end else if (hs) begin
          nxt_state = ST_IDLE;
        end else begin
          park = OUT_VALID;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
    if (park) begin
      if (!pend_vld) begin
        nxt_pend     = ALU_OUT;
        nxt_pend_vld = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  // Outputs are computed from next-state values so they leave a flop directly.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      active   <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      TX_DATA  <= '0;
      TX_VALID <= 1'b0;
      BUSY     <= 1'b0;
      OVERFLOW <= 1'b0;
      DROP_CNT <= '0;
    end else begin
      state    <= nxt_state;
      active   <= nxt_active;
      pend     <= nxt_pend;
      pend_vld <= nxt_pend_vld;
      TX_VALID <= (nxt_state != ST_IDLE);
      BUSY     <= (nxt_state != ST_IDLE) || nxt_pend_vld;
      OVERFLOW <= drop;
      if (nxt_state == ST_SEND_LO)
        TX_DATA <= nxt_active[BYTE_WIDTH-1:0];
      else if (nxt_state == ST_SEND_HI)
        TX_DATA <= nxt_active[OUT_WIDTH-1:BYTE_WIDTH];
      else
        TX_DATA <= '0;
      if (drop && (DROP_CNT != {CNT_WIDTH{1'b1}}))
        DROP_CNT <= DROP_CNT + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed, table-driven bench for alu_result_serializer plus hand-written
// sequences for reset mid-transfer and drop counter saturation.
module tb_alu_result_serializer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] ALU_OUT;
  logic        OUT_VALID;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;
  logic        BUSY;
  logic        OVERFLOW;
  logic [7:0]  DROP_CNT;

  int pass_cnt  = 0;
  int check_cnt = 0;

  alu_result_serializer dut (
    .CLK       (CLK),
    .RST       (RST),
    .ALU_OUT   (ALU_OUT),
    .OUT_VALID (OUT_VALID),
    .TX_DATA   (TX_DATA),
    .TX_VALID  (TX_VALID),
    .TX_READY  (TX_READY),
    .BUSY      (BUSY),
    .OVERFLOW  (OVERFLOW),
    .DROP_CNT  (DROP_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ov;
    logic [15:0] alu;
    logic        rdy;
    logic        e_valid;
    logic [7:0]  e_data;
    logic        e_busy;
    logic        e_ovf;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Inputs settle before the edge; outputs are sampled 1 time unit after it.
  task automatic applyStimulus(input logic ov, input logic [15:0] alu, input logic rdy);
    OUT_VALID = ov;
    ALU_OUT   = alu;
    TX_READY  = rdy;
    @(posedge CLK);
    #1;
  endtask

  task automatic addVec(input logic ov, input logic [15:0] alu, input logic rdy,
                        input logic ev, input logic [7:0] ed, input logic eb,
                        input logic eo, input logic [7:0] ec);
    vec_t v;
    v.ov = ov; v.alu = alu; v.rdy = rdy;
    v.e_valid = ev; v.e_data = ed; v.e_busy = eb; v.e_ovf = eo; v.e_cnt = ec;
    vecs.push_back(v);
  endtask

  initial begin
    RST = 1'b1; OUT_VALID = 1'b0; ALU_OUT = '0; TX_READY = 1'b0;
    #1;
    checkOutput("reset TX_VALID", {15'd0, TX_VALID}, 16'd0);
    checkOutput("reset TX_DATA", {8'd0, TX_DATA}, 16'd0);
    checkOutput("reset BUSY", {15'd0, BUSY}, 16'd0);
    checkOutput("reset OVERFLOW", {15'd0, OVERFLOW}, 16'd0);
    checkOutput("reset DROP_CNT", {8'd0, DROP_CNT}, 16'd0);
    @(posedge CLK); #2;
    RST = 1'b0;
    @(posedge CLK); #1;

    // single result
    addVec(1, 16'hA55A, 1, 1, 8'h5A, 1, 0, 8'd0);
    addVec(0, 16'h0000, 1, 1, 8'hA5, 1, 0, 8'd0);
    addVec(0, 16'h0000, 1, 0, 8'h00, 0, 0, 8'd0);
    // backpressure
    addVec(1, 16'h1234, 0, 1, 8'h34, 1, 0, 8'd0);
    for (int i = 0; i < 5; i++) addVec(0, 16'h0000, 0, 1, 8'h34, 1, 0, 8'd0);
    addVec(0, 16'h0000, 1, 1, 8'h12, 1, 0, 8'd0);
    addVec(0, 16'h0000, 1, 0, 8'h00, 0, 0, 8'd0);
    // pending buffer, no gap
    addVec(1, 16'h1111, 1, 1, 8'h11, 1, 0, 8'd0);
    addVec(1, 16'h2222, 1, 1, 8'h11, 1, 0, 8'd0);
    addVec(0, 16'h0000, 1, 1, 8'h22, 1, 0, 8'd0);
    addVec(0, 16'h0000, 1, 1, 8'h22, 1, 0, 8'd0);
    addVec(0, 16'h0000, 1, 0, 8'h00, 0, 0, 8'd0);
    // overflow
    addVec(1, 16'h0001, 0, 1, 8'h01, 1, 0, 8'd0);
    addVec(1, 16'h0002, 0, 1, 8'h01, 1, 0, 8'd0);
    addVec(1, 16'h0003, 0, 1, 8'h01, 1, 1, 8'd1);
    addVec(0, 16'h0000, 0, 1, 8'h01, 1, 0, 8'd1);
    addVec(0, 16'h0000, 1, 1, 8'h00, 1, 0, 8'd1);
    addVec(0, 16'h0000, 1, 1, 8'h02, 1, 0, 8'd1);
    addVec(0, 16'h0000, 1, 1, 8'h00, 1, 0, 8'd1);
    addVec(0, 16'h0000, 1, 0, 8'h00, 0, 0, 8'd1);
    // SEND_HI handshake with pending full and a new result
    addVec(1, 16'hABCD, 1, 1, 8'hCD, 1, 0, 8'd1);
    addVec(1, 16'h1357, 1, 1, 8'hAB, 1, 0, 8'd1);
    addVec(1, 16'h9BDF, 1, 1, 8'h57, 1, 0, 8'd1);
    addVec(0, 16'h0000, 1, 1, 8'h13, 1, 0, 8'd1);
    addVec(0, 16'h0000, 1, 1, 8'hDF, 1, 0, 8'd1);
    addVec(0, 16'h0000, 1, 1, 8'h9B, 1, 0, 8'd1);
    addVec(0, 16'h0000, 1, 0, 8'h00, 0, 0, 8'd1);
    // SEND_HI handshake with pending empty and a new result
    addVec(1, 16'h4455, 1, 1, 8'h55, 1, 0, 8'd1);
    addVec(0, 16'h0000, 1, 1, 8'h44, 1, 0, 8'd1);
    addVec(1, 16'h6677, 1, 1, 8'h77, 1, 0, 8'd1);
    addVec(0, 16'h0000, 1, 1, 8'h66, 1, 0, 8'd1);
    addVec(0, 16'h0000, 1, 0, 8'h00, 0, 0, 8'd1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ov, vecs[i].alu, vecs[i].rdy);
      checkOutput($sformatf("vec%0d TX_VALID", i), {15'd0, TX_VALID}, {15'd0, vecs[i].e_valid});
      checkOutput($sformatf("vec%0d TX_DATA", i), {8'd0, TX_DATA}, {8'd0, vecs[i].e_data});
      checkOutput($sformatf("vec%0d BUSY", i), {15'd0, BUSY}, {15'd0, vecs[i].e_busy});
      checkOutput($sformatf("vec%0d OVERFLOW", i), {15'd0, OVERFLOW}, {15'd0, vecs[i].e_ovf});
      checkOutput($sformatf("vec%0d DROP_CNT", i), {8'd0, DROP_CNT}, {8'd0, vecs[i].e_cnt});
    end

    // reset asserted while the high byte is on the bus, pending occupied
    applyStimulus(1, 16'hBEEF, 1);
    applyStimulus(1, 16'h7788, 1);
    checkOutput("pre-reset TX_DATA", {8'd0, TX_DATA}, 16'h00BE);
    RST = 1'b1;
    #1;
    checkOutput("async reset TX_VALID", {15'd0, TX_VALID}, 16'd0);
    checkOutput("async reset DROP_CNT", {8'd0, DROP_CNT}, 16'd0);
    checkOutput("async reset BUSY", {15'd0, BUSY}, 16'd0);
    applyStimulus(0, 16'h0000, 1);
    RST = 1'b0;
    applyStimulus(0, 16'h0000, 1);
    checkOutput("post-reset idle TX_VALID", {15'd0, TX_VALID}, 16'd0);
    applyStimulus(1, 16'hCAFE, 1);
    checkOutput("restart lo", {7'd0, TX_VALID, TX_DATA}, 16'h01FE);
    applyStimulus(0, 16'h0000, 1);
    checkOutput("restart hi", {7'd0, TX_VALID, TX_DATA}, 16'h01CA);
    applyStimulus(0, 16'h0000, 1);
    checkOutput("restart done", {6'd0, BUSY, TX_VALID, TX_DATA}, 16'h0000);

    // saturation: fill active and pending, then 260 drops
    applyStimulus(1, 16'h0102, 0);
    applyStimulus(1, 16'h0304, 0);
    for (int i = 0; i < 254; i++) applyStimulus(1, 16'(i), 0);
    checkOutput("drop cnt 254", {8'd0, DROP_CNT}, 16'h00FE);
    for (int i = 0; i < 6; i++) applyStimulus(1, 16'(i), 0);
    checkOutput("drop cnt saturated", {8'd0, DROP_CNT}, 16'h00FF);
    checkOutput("overflow at saturation", {15'd0, OVERFLOW}, 16'd1);
    applyStimulus(0, 16'h0000, 1);
    checkOutput("drain 1", {7'd0, TX_VALID, TX_DATA}, 16'h0101);
    applyStimulus(0, 16'h0000, 1);
    checkOutput("drain 2", {7'd0, TX_VALID, TX_DATA}, 16'h0104);
    applyStimulus(0, 16'h0000, 1);
    checkOutput("drain 3", {7'd0, TX_VALID, TX_DATA}, 16'h0103);
    applyStimulus(0, 16'h0000, 1);
    checkOutput("drain idle", {6'd0, BUSY, TX_VALID, TX_DATA}, 16'h0000);
    checkOutput("drop cnt held", {8'd0, DROP_CNT}, 16'h00FF);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
